// File: rtl/namuru_wb_pkg.sv
// Shared types and constants for the Namuru Wishbone arbiter.
package namuru_wb_pkg;

  localparam int unsigned ADR_W       = 32;
  localparam int unsigned DAT_W       = 32;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Request payload forwarded from the granted master to the slave.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
  } wb_req_t;

endpackage

// File: rtl/namuru_wb_rr_pick.sv
// Round-robin winner selection between two requesters.
module namuru_wb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // A lone requester wins; on contention the one not served last wins.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/namuru_wb_arbiter.sv
// Two-master Wishbone arbiter with per-transaction grant, idle gap and ack watchdog.
module namuru_wb_arbiter
  import namuru_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] req;
  logic       pick_valid;
  logic       pick_winner;
  logic       req_gnt;
  logic [1:0] m_ack;
  logic [1:0] m_err;
  wb_req_t    req0_s, req1_s, req_sel;

  assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign req_gnt = req[gnt_q];

  assign req0_s  = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i};
  assign req1_s  = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i};
  assign req_sel = gnt_q ? req1_s : req0_s;

  assign s_adr_o = req_sel.adr;
  assign s_dat_o = req_sel.dat;
  assign s_sel_o = req_sel.sel;
  assign s_we_o  = req_sel.we;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = m_ack[0];
  assign m1_ack_o = m_ack[1];
  assign m0_err_o = m_err[0];
  assign m1_err_o = m_err[1];

  namuru_wb_rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // State, grant, round-robin history and watchdog counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant in IDLE, complete/timeout/abort in BUSY, swallow stale ack in DRAIN.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_winner;
          last_d  = pick_winner;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ack_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST || !req_gnt) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (s_ack_i || cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: slave request while BUSY; ack or watchdog error to the granted master only.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack   = 2'b00;
    m_err   = 2'b00;
    if (state_q == ST_BUSY) begin
      s_cyc_o = 1'b1;
      s_stb_o = 1'b1;
      if (s_ack_i) begin
        m_ack[gnt_q] = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        m_err[gnt_q] = 1'b1;
      end
    end
  end

endmodule
